alu_cmd_issuer: RTL and testbench
=================================

// Module: alu_cmd_issuer
// PURPOSE
// - Sequential initiator for the generated combinational ALUs. It is the driving end of the opcode/input1/input2/shiftValue -> result/flags interface.
// - Buffers commands arriving on a valid/ready port and issues them to the ALU one at a time.
// - Waits a fixed settle latency, then captures result and the four flags.
// - Returns one response per command, in order, on a valid/ready port.
// PARAMETERS
// - WIDTH       128  operand/result width; must match the attached ALU
// - FIFO_DEPTH  4    command FIFO entries; power of 2, >=2
// - ALU_LAT     1    cycles between driving ALU inputs and sampling outputs; >=1
// PORTS
// - clk               in   1      single clock, all logic posedge
// - rst               in   1      synchronous reset, active-high
// - cmd_valid         in   1      command present
// - cmd_ready         out  1      command accepted when valid&ready
// - cmd_opcode        in   4      ALU opcode (0 ADD,1 SUB,2 AND,3 OR,4 MUL,5 PASSB,6 DIV,7 XNOR,8 XOR)
// - cmd_a / cmd_b     in   WIDTH  operands
// - cmd_shift         in   5      shift amount, passed through
// - rsp_valid         out  1      response present
// - rsp_ready         in   1      response consumed when valid&ready
// - rsp_result        out  WIDTH  captured ALU result
// - rsp_flags         out  4      {carry, zero, overflow, sign}
// - rsp_err           out  1      divide-by-zero trap (see CONFIGURATION)
// - alu_opcode        out  4      registered drive to ALU opcode
// - alu_input1/2      out  WIDTH  registered drive to ALU input1/input2
// - alu_shiftValue    out  5      registered drive to ALU shiftValue
// - alu_result        in   WIDTH  ALU result
// - alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag  in 1 each
// - busy              out  1      FSM not IDLE or FIFO non-empty
// BEHAVIOUR
// - Reset values:
//   - cmd_ready=1; rsp_valid=0; rsp_result=0; rsp_flags=0; rsp_err=0.
//   - alu_opcode=0; alu_input1=0; alu_input2=0; alu_shiftValue=0.
//   - busy=0; FIFO empty; FSM=IDLE.
// - FIFO:
//   - cmd_ready = (count < FIFO_DEPTH), derived from registered count.
//   - Simultaneous push and pop in one cycle leaves count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
// - FSM states IDLE, WAIT, RESP:
//   - IDLE: if FIFO non-empty, pop head, load alu_* regs from it, load lat_cnt=ALU_LAT, go to WAIT. Otherwise stay.
//   - WAIT: alu_* held. Decrement lat_cnt. When lat_cnt==1, capture alu_result and the flags into rsp_*, set rsp_valid, go to RESP.
//   - RESP: hold rsp_* stable while rsp_ready=0. On valid&ready, clear rsp_valid and go to IDLE.
// - alu_* regs change only on the IDLE pop. They keep the last command between operations.
// - Latency: command handshake in cycle N with FIFO empty and FSM idle gives alu_* valid from N+2 and rsp_valid from N+2+ALU_LAT. With ALU_LAT=1 that is N+3.
// - Throughput: one command per ALU_LAT+2 cycles when rsp_ready=1.
// - Ordering: responses strictly in command order. No drop, no duplication.
// - Capacity: FIFO_DEPTH queued plus 1 in flight. With rsp stalled, FIFO_DEPTH+1 commands are accepted before cmd_ready falls.
// - No width extension: rsp_result is alu_result verbatim, and flags are copied as sampled.
// - Reset mid-operation: any state, FIFO contents and in-flight command are discarded. Outputs return to reset values the cycle after rst is sampled high. No stale response follows.
// CONFIGURATION
// - Macro ALU_CMD_ISSUER_DIVZERO_TRAP_EN:
// - Defined: an IDLE pop with opcode==6 and operand b==0 is not issued.
//   - alu_* regs are unchanged.
//   - FSM goes straight to RESP with rsp_result=0, rsp_flags=4'b0100, rsp_err=1.
//   - rsp_err=0 for every other response.
// - Undefined: DIV with b==0 is issued like any other command, and rsp_err is tied 0.
// TESTING
// - Reset: hold rst 2 cycles -> cmd_ready=1, rsp_valid=0, busy=0, alu_opcode=0, alu_input1=0.
// - ADD, ALU_LAT=1: cmd 0, a=5, b=7 handshake at cycle N -> alu_opcode=0 at N+2, rsp_valid at N+3, rsp_result=12, zero=0, sign=0.
// - Fill: rsp_ready=0, push SUB 10-i for i=0..5 -> 5 accepted, cmd_ready=0 on the 6th. Raise rsp_ready -> 5 responses in order: 10,9,8,7,6. Then 6th accepted.
// - Backpressure: response pending, rsp_ready=0 for 10 cycles -> rsp_valid=1, rsp_result and rsp_flags constant, no new alu_* load.
// - Div-by-zero: opcode 6, a=9, b=0:
//   - Macro defined: rsp_err=1, rsp_result=0, rsp_flags=4'b0100, alu_opcode unchanged.
//   - Macro undefined: alu_opcode=6, rsp_err=0.
// - Reset mid-op: rst high during WAIT with 2 queued -> next cycle rsp_valid=0, busy=0, cmd_ready=1. No response for any discarded command.

Source files
------------

// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: command and response valid/ready channels of the ALU command issuer.
interface alu_cmd_issuer_if #(
    parameter int WIDTH = 128
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_opcode;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [4:0]       cmd_shift;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;
    logic             rsp_err;
    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shift, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
    );
    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shift, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, drives the ALU one at a time and returns captured results in order.
// Define ALU_CMD_ISSUER_DIVZERO_TRAP_EN to answer DIV by zero locally with rsp_err instead of issuing it.
module alu_cmd_issuer #(
    parameter int WIDTH      = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_issuer_if.slave  bus,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_shiftValue,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryFlag,
    input  logic             alu_zeroFlag,
    input  logic             alu_overFlowFlag,
    input  logic             alu_signFlag,
    output logic             busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 4 + 2 * WIDTH + 5;
    localparam int LW = $clog2(ALU_LAT + 1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t           state;
    logic [EW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [LW-1:0]    lat_cnt;
    logic             push, pop, trap;
    logic [3:0]       head_op;
    logic [WIDTH-1:0] head_a, head_b;
    logic [4:0]       head_shift;
    assign {head_op, head_a, head_b, head_shift} = mem[rd_ptr];
    assign bus.cmd_ready = count < (AW+1)'(FIFO_DEPTH);
    assign push = bus.cmd_valid && bus.cmd_ready;
    assign pop = state == IDLE && count != '0;
    assign busy = state != IDLE || count != '0;
`ifdef ALU_CMD_ISSUER_DIVZERO_TRAP_EN
    assign trap = head_op == 4'd6 && head_b == '0;
`else
    assign trap = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.cmd_opcode, bus.cmd_a, bus.cmd_b, bus.cmd_shift};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // alu_* only move on a real issue, so the ALU sees the last command between operations
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lat_cnt        <= '0;
            alu_opcode     <= '0;
            alu_input1     <= '0;
            alu_input2     <= '0;
            alu_shiftValue <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_flags  <= '0;
            bus.rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    if (trap) begin
                        bus.rsp_result <= '0;
                        bus.rsp_flags  <= 4'b0100;
                        bus.rsp_err    <= 1'b1;
                        bus.rsp_valid  <= 1'b1;
                        state          <= RESP;
                    end else begin
                        alu_opcode     <= head_op;
                        alu_input1     <= head_a;
                        alu_input2     <= head_b;
                        alu_shiftValue <= head_shift;
                        lat_cnt        <= LW'(ALU_LAT);
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LW'(1)) begin
                        bus.rsp_result <= alu_result;
                        bus.rsp_flags  <= {alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag};
                        bus.rsp_err    <= 1'b0;
                        bus.rsp_valid  <= 1'b1;
                        state          <= RESP;
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed vectors through a behavioural ALU plus fill, backpressure, div-by-zero and reset sequences.
module tb_alu_cmd_issuer;
    localparam int W = 128;
    localparam int NV = 11;
    logic clk = 1'b0;
    logic rst;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_input1, alu_input2, alu_result;
    logic [4:0]   alu_shiftValue;
    logic         alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag;
    logic         busy;
    logic [W:0]   ext;
    int checks = 0;
    int errors = 0;
    alu_cmd_issuer_if #(.WIDTH(W)) bus ();
    alu_cmd_issuer dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shiftValue(alu_shiftValue), .alu_result(alu_result),
        .alu_carryFlag(alu_carryFlag), .alu_zeroFlag(alu_zeroFlag),
        .alu_overFlowFlag(alu_overFlowFlag), .alu_signFlag(alu_signFlag), .busy(busy)
    );
    always #5 clk = ~clk;
    // behavioural ALU; carry is the borrow for SUB
    always_comb begin
        ext = '0;
        alu_overFlowFlag = 1'b0;
        case (alu_opcode)
            4'd0: begin
                ext = {1'b0, alu_input1} + {1'b0, alu_input2};
                alu_overFlowFlag = alu_input1[W-1] == alu_input2[W-1] && ext[W-1] != alu_input1[W-1];
            end
            4'd1: begin
                ext = {1'b0, alu_input1} - {1'b0, alu_input2};
                alu_overFlowFlag = alu_input1[W-1] != alu_input2[W-1] && ext[W-1] != alu_input1[W-1];
            end
            4'd2: ext = {1'b0, alu_input1 & alu_input2};
            4'd3: ext = {1'b0, alu_input1 | alu_input2};
            4'd4: ext = {1'b0, alu_input1 * alu_input2};
            4'd5: ext = {1'b0, alu_input2};
            4'd6: ext = {1'b0, (alu_input2 == '0) ? {W{1'b1}} : alu_input1 / alu_input2};
            4'd7: ext = {1'b0, ~(alu_input1 ^ alu_input2)};
            4'd8: ext = {1'b0, alu_input1 ^ alu_input2};
            default: ext = '0;
        endcase
        alu_result    = ext[W-1:0];
        alu_carryFlag = ext[W];
        alu_zeroFlag  = ext[W-1:0] == '0;
        alu_signFlag  = ext[W-1];
    end
    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   fl;
    } vec_t;
    vec_t vecs [NV];
    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic push(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh, output bit ok);
        bus.cmd_valid = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_shift = sh;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = bus.cmd_ready;
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
    endtask
    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask
    task automatic ack();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask
    task automatic get_rsp(input string nm, input logic [W-1:0] exp);
        bit ok;
        wait_rsp(ok);
        chk({nm, "_valid"}, W'(ok), 1);
        chk({nm, "_result"}, bus.rsp_result, exp);
        ack();
    endtask
    initial begin
        bit ok;
        bit stable;
        int spurious;
        vecs[0]  = '{4'd0, 128'd5, 128'd7, 128'd12, 4'b0000};
        vecs[1]  = '{4'd1, 128'd3, 128'd5, {{(W-1){1'b1}}, 1'b0}, 4'b1001};
        vecs[2]  = '{4'd2, 128'hF0, 128'h3C, 128'h30, 4'b0000};
        vecs[3]  = '{4'd3, 128'd0, 128'd0, 128'd0, 4'b0100};
        vecs[4]  = '{4'd4, 128'd6, 128'd7, 128'd42, 4'b0000};
        vecs[5]  = '{4'd5, 128'd1, 128'd99, 128'd99, 4'b0000};
        vecs[6]  = '{4'd6, 128'd100, 128'd7, 128'd14, 4'b0000};
        vecs[7]  = '{4'd8, 128'hFF, 128'hFF, 128'd0, 4'b0100};
        vecs[8]  = '{4'd7, 128'd0, 128'd0, {W{1'b1}}, 4'b0001};
        vecs[9]  = '{4'd0, {1'b0, {(W-1){1'b1}}}, 128'd1, {1'b1, {(W-1){1'b0}}}, 4'b0011};
        vecs[10] = '{4'd0, {W{1'b1}}, 128'd1, 128'd0, 4'b1100};
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_opcode = '0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_shift = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", W'(bus.cmd_ready), 1);
        chk("rst_rsp_valid", W'(bus.rsp_valid), 0);
        chk("rst_busy", W'(busy), 0);
        chk("rst_alu_opcode", W'(alu_opcode), 0);
        chk("rst_alu_input1", alu_input1, 0);
        rst = 1'b0;
        for (int i = 0; i < NV; i++) begin
            push(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i), ok);
            chk("vec_accept", W'(ok), 1);
            chk("vec_lat_n1", W'(bus.rsp_valid), 0);
            @(posedge clk); #1;
            chk("vec_alu_opcode", W'(alu_opcode), W'(vecs[i].op));
            chk("vec_alu_input1", alu_input1, vecs[i].a);
            chk("vec_alu_input2", alu_input2, vecs[i].b);
            chk("vec_alu_shift", W'(alu_shiftValue), W'(i));
            chk("vec_lat_n2", W'(bus.rsp_valid), 0);
            @(posedge clk); #1;
            chk("vec_rsp_valid", W'(bus.rsp_valid), 1);
            chk("vec_result", bus.rsp_result, vecs[i].res);
            chk("vec_flags", W'(bus.rsp_flags), W'(vecs[i].fl));
            chk("vec_err", W'(bus.rsp_err), 0);
            ack();
            chk("vec_rsp_cleared", W'(bus.rsp_valid), 0);
        end
        push(4'd0, 128'd1, 128'd1, 5'd0, ok);
        chk("bp_accept", W'(ok), 1);
        wait_rsp(ok);
        chk("bp_rsp", W'(ok), 1);
        push(4'd3, 128'hA, 128'h5, 5'd0, ok);
        chk("bp_queue_accept", W'(ok), 1);
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!bus.rsp_valid || bus.rsp_result !== 128'd2 || bus.rsp_flags !== 4'b0000 ||
                alu_opcode !== 4'd0 || alu_input1 !== 128'd1) stable = 1'b0;
        end
        chk("bp_stable", W'(stable), 1);
        get_rsp("bp_first", 128'd2);
        get_rsp("bp_second", 128'hF);
        for (int i = 0; i < 5; i++) begin
            push(4'd1, 128'd10, W'(i), 5'd0, ok);
            chk("fill_accept", W'(ok), 1);
        end
        chk("fill_full_ready", W'(bus.cmd_ready), 0);
        @(posedge clk); #1;
        chk("fill_still_full", W'(bus.cmd_ready), 0);
        get_rsp("fill_r10", 128'd10);
        push(4'd1, 128'd10, 128'd5, 5'd0, ok);
        chk("fill_sixth_accept", W'(ok), 1);
        for (int i = 1; i < 6; i++) get_rsp("fill_order", W'(10 - i));
        chk("fill_idle_busy", W'(busy), 0);
        push(4'd6, 128'd9, 128'd0, 5'd0, ok);
        chk("dz_accept", W'(ok), 1);
        wait_rsp(ok);
        chk("dz_rsp", W'(ok), 1);
`ifdef ALU_CMD_ISSUER_DIVZERO_TRAP_EN
        chk("dz_err", W'(bus.rsp_err), 1);
        chk("dz_result", bus.rsp_result, 0);
        chk("dz_flags", W'(bus.rsp_flags), W'(4'b0100));
        chk("dz_alu_opcode_kept", W'(alu_opcode), 1);
`else
        chk("dz_err", W'(bus.rsp_err), 0);
        chk("dz_alu_opcode", W'(alu_opcode), 6);
`endif
        ack();
        for (int i = 0; i < 4; i++) begin
            push(4'd0, W'(i), 128'd100, 5'd0, ok);
            chk("mr_accept", W'(ok), 1);
        end
        wait_rsp(ok);
        chk("mr_first_rsp", W'(ok), 1);
        ack();
        @(posedge clk); #1;
        chk("mr_busy_before", W'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mr_rsp_valid", W'(bus.rsp_valid), 0);
        chk("mr_busy", W'(busy), 0);
        chk("mr_cmd_ready", W'(bus.cmd_ready), 1);
        chk("mr_alu_opcode", W'(alu_opcode), 0);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        spurious = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) spurious++;
        end
        bus.rsp_ready = 1'b0;
        chk("mr_no_stale", W'(spurious), 0);
        push(4'd0, 128'd2, 128'd3, 5'd0, ok);
        chk("mr_recover_accept", W'(ok), 1);
        get_rsp("mr_recover", 128'd5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
